debug_frame_sequencer: RTL and testbench

Host-side command sequencer that drives the pipeline's 32-bit debug frame port and collects readback words from it. It sits directly upstream of `pipeline`: its `o_frame_from_blaze` feeds `pipeline.i_frame_from_blaze`, and its `i_frame_to_blaze` consumes `pipeline.o_frame_to_blaze`. It converts simple valid/ready host commands (instruction load, run, step, latch/memory read) into timed frame sequences and returns read data through a held response port.

---
 rtl/debug_frame_sequencer_if.sv | 24 ++
 rtl/debug_frame_sequencer.sv | 81 ++++++++
 tb/tb_debug_frame_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/debug_frame_sequencer_if.sv
// debug_frame_sequencer_if: host command, response and pipeline frame signals of the debug frame sequencer
interface debug_frame_sequencer_if #(
  parameter int NB_CONTROL_FRAME = 32,
  parameter int NB_INSTR_ADDR    = 9
) ();
  logic                        i_cmd_valid;
  logic                        o_cmd_ready;
  logic [2:0]                  i_cmd_op;
  logic [NB_INSTR_ADDR-1:0]    i_cmd_addr;
  logic [NB_CONTROL_FRAME-1:0] i_cmd_data;
  logic [NB_CONTROL_FRAME-1:0] o_frame_from_blaze;
  logic [NB_CONTROL_FRAME-1:0] i_frame_to_blaze;
  logic                        o_rsp_valid;
  logic [NB_CONTROL_FRAME-1:0] o_rsp_data;
  logic                        i_rsp_ready;
  modport master (
    output i_cmd_valid, i_cmd_op, i_cmd_addr, i_cmd_data, i_frame_to_blaze, i_rsp_ready,
    input  o_cmd_ready, o_frame_from_blaze, o_rsp_valid, o_rsp_data
  );
  modport slave (
    input  i_cmd_valid, i_cmd_op, i_cmd_addr, i_cmd_data, i_frame_to_blaze, i_rsp_ready,
    output o_cmd_ready, o_frame_from_blaze, o_rsp_valid, o_rsp_data
  );
endinterface

// File: rtl/debug_frame_sequencer.sv
// debug_frame_sequencer: turns host commands into timed 32-bit debug frames and returns readback words
module debug_frame_sequencer #(
  parameter int NB_ADDR_DATA = 16,
  parameter int READ_LATENCY = 2
) (
  input logic                   i_clock,
  input logic                   i_reset,
  debug_frame_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, INSTR_LO, INSTR_HI, CTRL, READ_REQ, READ_WAIT, RSP} state_t;
  localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);
  state_t      state, state_d;
  logic [2:0]  op, op_d;
  logic [8:0]  addr, addr_d;
  logic [31:0] data, data_d, frame_d, rsp_data_d;
  logic [3:0]  cnt, cnt_d;
  logic        rsp_valid_d;
  always_comb begin
    state_d     = state;
    op_d        = op;
    addr_d      = addr;
    data_d      = data;
    cnt_d       = cnt;
    rsp_valid_d = bus.o_rsp_valid;
    rsp_data_d  = bus.o_rsp_data;
    case (state)
      IDLE: if (bus.i_cmd_valid && bus.o_cmd_ready) begin
        op_d    = bus.i_cmd_op;
        addr_d  = bus.i_cmd_addr;
        data_d  = bus.i_cmd_data;
        cnt_d   = LAT_M1;
        state_d = bus.i_cmd_op == 3'd1 ? INSTR_LO :
                  (bus.i_cmd_op == 3'd2 || bus.i_cmd_op == 3'd3) ? CTRL :
                  bus.i_cmd_op == 3'd4 ? READ_REQ : IDLE;
      end
      INSTR_LO: state_d = INSTR_HI;
      INSTR_HI, CTRL: state_d = IDLE;
      // The latency count runs from the request frame's cycle, so a latency of 1 captures on leaving READ_REQ.
      READ_REQ, READ_WAIT: if (cnt == 4'd0) begin
        state_d     = RSP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = bus.i_frame_to_blaze;
      end else begin
        cnt_d   = cnt - 4'd1;
        state_d = READ_WAIT;
      end
      RSP: if (bus.i_rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Regfile ID 0 would alias the idle frame, so bit 25 marks it.
    frame_d = state_d == INSTR_LO ? {6'b000001, 1'b0, addr_d, data_d[NB_ADDR_DATA-1:0]} :
              state_d == INSTR_HI ? {6'b000010, 1'b0, addr_d, data_d[31:NB_ADDR_DATA]} :
              state_d == CTRL     ? {(op_d == 3'd3 ? 6'b000100 : 6'b000011), 26'd0} :
              state_d == READ_REQ ? {addr_d[5:0], addr_d[5:0] == 6'd0, 20'd0, data_d[4:0]} : 32'd0;
  end
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      state                  <= IDLE;
      op                     <= '0;
      addr                   <= '0;
      data                   <= '0;
      cnt                    <= '0;
      bus.o_frame_from_blaze <= '0;
      bus.o_cmd_ready        <= 1'b0;
      bus.o_rsp_valid        <= 1'b0;
      bus.o_rsp_data         <= '0;
    end else begin
      state                  <= state_d;
      op                     <= op_d;
      addr                   <= addr_d;
      data                   <= data_d;
      cnt                    <= cnt_d;
      bus.o_frame_from_blaze <= frame_d;
      bus.o_cmd_ready        <= state_d == IDLE;
      bus.o_rsp_valid        <= rsp_valid_d;
      bus.o_rsp_data         <= rsp_data_d;
    end
endmodule

// File: tb/tb_debug_frame_sequencer.sv
// tb_debug_frame_sequencer: randomized checks of frame sequences and readback against a frame-rule model
module tb_debug_frame_sequencer;
  localparam int LAT = 2;
  logic tb_clock_i = 1'b0;
  logic rst_n;
  int checks = 0;
  int failures = 0;
  always #5 tb_clock_i = ~tb_clock_i;
  debug_frame_sequencer_if b0 ();
  debug_frame_sequencer_if b1 ();
  debug_frame_sequencer #(.READ_LATENCY(LAT)) u0 (.i_clock(tb_clock_i), .i_reset(rst_n), .bus(b0.slave));
  debug_frame_sequencer #(.READ_LATENCY(1)) u1 (.i_clock(tb_clock_i), .i_reset(rst_n), .bus(b1.slave));

  function automatic logic [31:0] instr_frame(input bit hi, input logic [8:0] a, input logic [31:0] d);
    return (hi ? 32'd2 : 32'd1) * 32'h0400_0000 + {23'd0, a} * 32'h1_0000 + (hi ? d / 32'h1_0000 : d % 32'h1_0000);
  endfunction
  function automatic logic [31:0] read_frame(input logic [5:0] id, input logic [4:0] idx);
    return {26'd0, id} * 32'h0400_0000 + (id == 6'd0 ? 32'h0200_0000 : 32'd0) + {27'd0, idx};
  endfunction
  function automatic logic [31:0] ctrl_frame(input logic [2:0] op);
    return (op == 3'd3 ? 32'd4 : 32'd3) * 32'h0400_0000;
  endfunction

  task automatic tick;
    @(posedge tb_clock_i);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [8:0] a, input logic [31:0] d);
    int n = 0;
    while (b0.o_cmd_ready !== 1'b1 && n < 20) begin tick; n++; end
    checks++; if (n == 20) begin failures++; $display("FAIL ready_timeout: ready=%b want 1", b0.o_cmd_ready); end
    b0.i_cmd_valid = 1'b1; b0.i_cmd_op = op; b0.i_cmd_addr = a; b0.i_cmd_data = d;
    tick;
    b0.i_cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (b0.o_cmd_ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b want 0", b0.o_cmd_ready); end
    checks++; if (b0.o_frame_from_blaze !== 32'd0) begin failures++; $display("FAIL rst_frame: got %h want 0", b0.o_frame_from_blaze); end
    checks++; if (b0.o_rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid: got %b want 0", b0.o_rsp_valid); end
    checks++; if (b0.o_rsp_data !== 32'd0) begin failures++; $display("FAIL rst_rsp_data: got %h want 0", b0.o_rsp_data); end
    tick; tick;
    rst_n = 1'b1;
    tick;
    checks++; if (b0.o_cmd_ready !== 1'b1) begin failures++; $display("FAIL rel_ready: got %b want 1", b0.o_cmd_ready); end
    checks++; if (b1.o_cmd_ready !== 1'b1) begin failures++; $display("FAIL rel_ready1: got %b want 1", b1.o_cmd_ready); end
  endtask

  task automatic test_write_instr_back_to_back;
    logic [8:0] a;
    logic [31:0] d;
    for (int i = 0; i < 6; i++) begin
      a = (i == 0) ? 9'h005 : 9'($urandom_range(0, 511));
      d = (i == 0) ? 32'hDEADBEEF : $urandom;
      issue(3'd1, a, d);
      checks++; if (b0.o_frame_from_blaze !== instr_frame(0, a, d)) begin failures++; $display("FAIL instr_lo: got %h want %h", b0.o_frame_from_blaze, instr_frame(0, a, d)); end
      checks++; if (b0.o_cmd_ready !== 1'b0) begin failures++; $display("FAIL instr_busy1: got %b want 0", b0.o_cmd_ready); end
      tick;
      checks++; if (b0.o_frame_from_blaze !== instr_frame(1, a, d)) begin failures++; $display("FAIL instr_hi: got %h want %h", b0.o_frame_from_blaze, instr_frame(1, a, d)); end
      checks++; if (b0.o_cmd_ready !== 1'b0) begin failures++; $display("FAIL instr_busy2: got %b want 0", b0.o_cmd_ready); end
      tick;
      checks++; if (b0.o_frame_from_blaze !== 32'd0) begin failures++; $display("FAIL instr_idle: got %h want 0", b0.o_frame_from_blaze); end
      checks++; if (b0.o_cmd_ready !== 1'b1) begin failures++; $display("FAIL instr_ready3: got %b want 1", b0.o_cmd_ready); end
    end
  endtask

  task automatic test_ctrl;
    logic [2:0] ops [4] = '{3'd3, 3'd2, 3'd2, 3'd3};
    foreach (ops[i]) begin
      issue(ops[i], 9'($urandom), $urandom);
      checks++; if (b0.o_frame_from_blaze !== ctrl_frame(ops[i])) begin failures++; $display("FAIL ctrl_frame: got %h want %h", b0.o_frame_from_blaze, ctrl_frame(ops[i])); end
      checks++; if (b0.o_cmd_ready !== 1'b0) begin failures++; $display("FAIL ctrl_busy: got %b want 0", b0.o_cmd_ready); end
      tick;
      checks++; if (b0.o_frame_from_blaze !== 32'd0) begin failures++; $display("FAIL ctrl_idle: got %h want 0", b0.o_frame_from_blaze); end
      checks++; if (b0.o_cmd_ready !== 1'b1) begin failures++; $display("FAIL ctrl_ready: got %b want 1", b0.o_cmd_ready); end
    end
  endtask

  task automatic test_nop_illegal;
    logic [2:0] ops [4] = '{3'd0, 3'd5, 3'd6, 3'd7};
    foreach (ops[i]) begin
      issue(ops[i], 9'($urandom), $urandom);
      checks++; if (b0.o_frame_from_blaze !== 32'd0) begin failures++; $display("FAIL nop_frame op%0d: got %h want 0", ops[i], b0.o_frame_from_blaze); end
      checks++; if (b0.o_cmd_ready !== 1'b1) begin failures++; $display("FAIL nop_ready op%0d: got %b want 1", ops[i], b0.o_cmd_ready); end
    end
  endtask

  task automatic test_read(input logic [5:0] id, input logic [4:0] idx, input logic [31:0] w, input int hold);
    issue(3'd4, {3'd0, id}, {27'd0, idx});
    checks++; if (b0.o_frame_from_blaze !== read_frame(id, idx)) begin failures++; $display("FAIL read_frame: got %h want %h", b0.o_frame_from_blaze, read_frame(id, idx)); end
    for (int k = 0; k < LAT; k++) begin
      b0.i_frame_to_blaze = (k == LAT - 1) ? w : ~w;
      checks++; if (b0.o_rsp_valid !== 1'b0) begin failures++; $display("FAIL read_early_valid k%0d: got %b want 0", k, b0.o_rsp_valid); end
      tick;
    end
    b0.i_frame_to_blaze = $urandom;
    checks++; if (b0.o_frame_from_blaze !== 32'd0) begin failures++; $display("FAIL read_wait_frame: got %h want 0", b0.o_frame_from_blaze); end
    b0.i_cmd_valid = 1'b1; b0.i_cmd_op = 3'd2;
    for (int k = 0; k <= hold; k++) begin
      checks++; if (b0.o_rsp_valid !== 1'b1) begin failures++; $display("FAIL rsp_valid k%0d: got %b want 1", k, b0.o_rsp_valid); end
      checks++; if (b0.o_rsp_data !== w) begin failures++; $display("FAIL rsp_data k%0d: got %h want %h", k, b0.o_rsp_data, w); end
      checks++; if (b0.o_cmd_ready !== 1'b0) begin failures++; $display("FAIL rsp_ready_low k%0d: got %b want 0", k, b0.o_cmd_ready); end
      if (k < hold) tick;
    end
    b0.i_cmd_valid = 1'b0; b0.i_rsp_ready = 1'b1;
    tick;
    b0.i_rsp_ready = 1'b0;
    checks++; if (b0.o_rsp_valid !== 1'b0) begin failures++; $display("FAIL rsp_clear: got %b want 0", b0.o_rsp_valid); end
    checks++; if (b0.o_cmd_ready !== 1'b1) begin failures++; $display("FAIL rsp_ready_back: got %b want 1", b0.o_cmd_ready); end
    tick;
    checks++; if (b0.o_frame_from_blaze !== 32'd0) begin failures++; $display("FAIL rsp_not_queued: got %h want 0", b0.o_frame_from_blaze); end
  endtask

  task automatic test_reads;
    test_read(6'b101000, 5'd1, 32'h12345678, 5);
    test_read(6'b000000, 5'd31, $urandom, 0);
    for (int i = 0; i < 5; i++) test_read(6'($urandom), 5'($urandom), $urandom, $urandom_range(0, 3));
  endtask

  task automatic test_reset_mid_instr_hi;
    logic [31:0] d = $urandom;
    issue(3'd1, 9'h0A3, d);
    tick;
    checks++; if (b0.o_frame_from_blaze !== instr_frame(1, 9'h0A3, d)) begin failures++; $display("FAIL mid_hi: got %h want %h", b0.o_frame_from_blaze, instr_frame(1, 9'h0A3, d)); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (b0.o_frame_from_blaze !== 32'd0) begin failures++; $display("FAIL mid_rst_frame: got %h want 0", b0.o_frame_from_blaze); end
    checks++; if (b0.o_cmd_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_ready: got %b want 0", b0.o_cmd_ready); end
    tick; tick;
    rst_n = 1'b1;
    tick;
    checks++; if (b0.o_cmd_ready !== 1'b1) begin failures++; $display("FAIL mid_rel_ready: got %b want 1", b0.o_cmd_ready); end
    checks++; if (b0.o_frame_from_blaze !== 32'd0) begin failures++; $display("FAIL mid_rel_frame: got %h want 0", b0.o_frame_from_blaze); end
    tick;
    checks++; if (b0.o_frame_from_blaze !== 32'd0) begin failures++; $display("FAIL mid_no_reissue: got %h want 0", b0.o_frame_from_blaze); end
  endtask

  task automatic test_latency1;
    logic [31:0] w = $urandom;
    b1.i_cmd_valid = 1'b1; b1.i_cmd_op = 3'd7; b1.i_cmd_addr = 9'h1FF; b1.i_cmd_data = $urandom;
    tick;
    b1.i_cmd_valid = 1'b0;
    checks++; if (b1.o_frame_from_blaze !== 32'd0) begin failures++; $display("FAIL l1_op7_frame: got %h want 0", b1.o_frame_from_blaze); end
    checks++; if (b1.o_cmd_ready !== 1'b1) begin failures++; $display("FAIL l1_op7_ready: got %b want 1", b1.o_cmd_ready); end
    b1.i_cmd_valid = 1'b1; b1.i_cmd_op = 3'd4; b1.i_cmd_addr = 9'h024; b1.i_cmd_data = 32'd3;
    tick;
    b1.i_cmd_valid = 1'b0;
    b1.i_frame_to_blaze = w;
    checks++; if (b1.o_frame_from_blaze !== read_frame(6'h24, 5'd3)) begin failures++; $display("FAIL l1_read_frame: got %h want %h", b1.o_frame_from_blaze, read_frame(6'h24, 5'd3)); end
    checks++; if (b1.o_rsp_valid !== 1'b0) begin failures++; $display("FAIL l1_early_valid: got %b want 0", b1.o_rsp_valid); end
    tick;
    b1.i_frame_to_blaze = ~w;
    checks++; if (b1.o_rsp_valid !== 1'b1) begin failures++; $display("FAIL l1_valid: got %b want 1", b1.o_rsp_valid); end
    checks++; if (b1.o_rsp_data !== w) begin failures++; $display("FAIL l1_data: got %h want %h", b1.o_rsp_data, w); end
    b1.i_rsp_ready = 1'b1;
    tick;
    b1.i_rsp_ready = 1'b0;
    checks++; if (b1.o_rsp_valid !== 1'b0) begin failures++; $display("FAIL l1_clear: got %b want 0", b1.o_rsp_valid); end
    checks++; if (b1.o_cmd_ready !== 1'b1) begin failures++; $display("FAIL l1_ready_back: got %b want 1", b1.o_cmd_ready); end
  endtask

  initial begin
    rst_n = 1'b0;
    b0.i_cmd_valid = 1'b0; b0.i_cmd_op = '0; b0.i_cmd_addr = '0; b0.i_cmd_data = '0; b0.i_frame_to_blaze = '0; b0.i_rsp_ready = 1'b0;
    b1.i_cmd_valid = 1'b0; b1.i_cmd_op = '0; b1.i_cmd_addr = '0; b1.i_cmd_data = '0; b1.i_frame_to_blaze = '0; b1.i_rsp_ready = 1'b0;
    test_reset;
    test_write_instr_back_to_back;
    test_ctrl;
    test_nop_illegal;
    test_reads;
    test_reset_mid_instr_hi;
    test_latency1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
